// File: rtl/rv_seq_pkg.sv
// Shared definitions for the RV32 multi-cycle sequencer: state encoding and PC source selects.
package rv_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5,
        ST_FAULT  = 3'd7
    } seq_state_e;

    localparam logic [1:0] PC_SEL_PLUS4  = 2'b00;
    localparam logic [1:0] PC_SEL_BRANCH = 2'b01;
    localparam logic [1:0] PC_SEL_JUMP   = 2'b10;

    // Jump outranks a taken branch; anything else falls through to PC+4.
    function automatic logic [1:0] pc_sel_f(input logic jump, input logic taken);
        logic [1:0] sel;
        if (jump) begin
            sel = PC_SEL_JUMP;
        end else if (taken) begin
            sel = PC_SEL_BRANCH;
        end else begin
            sel = PC_SEL_PLUS4;
        end
        return sel;
    endfunction

endpackage

// File: rtl/seq_timeout_counter.sv
// Memory wait guard: counts non-ready request cycles and flags expiry on the cycle that reaches the limit.
module seq_timeout_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clear,
    input  logic         inc,
    input  logic [W-1:0] limit,
    output logic         expired
);

    logic [W-1:0] count_r;
    logic [W:0]   count_inc_s;

    // Expiry is flagged combinationally so the FSM leaves the request state on the limiting cycle.
    always_comb begin
        count_inc_s = {1'b0, count_r} + {{W{1'b0}}, 1'b1};
        if (inc) begin
            expired = (count_inc_s >= {1'b0, limit});
        end else begin
            expired = 1'b0;
        end
    end

    // Wait-cycle count; saturates at the limit since the FSM has already moved to FAULT.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_r <= {W{1'b0}};
        end else if (clear) begin
            count_r <= {W{1'b0}};
        end else if (inc && !expired) begin
            count_r <= count_inc_s[W-1:0];
        end else begin
            count_r <= count_r;
        end
    end

endmodule

// File: rtl/multicycle_sequencer.sv
// Multi-cycle RV32 sequencer: FETCH/DECODE/EXEC/MEM/WB over one shared memory port,
// with retired-instruction counting and a sticky FAULT state left only by reset.
module multicycle_sequencer
    import rv_seq_pkg::*;
#(
    parameter int CNT_W       = 32,
    parameter int MEM_TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             run,
    input  logic             ctrl_valid,
    input  logic             reg_write,
    input  logic             mem_read,
    input  logic             mem_write,
    input  logic             jump,
    input  logic             branch_taken,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             mem_we,
    output logic             mem_addr_sel,
    output logic             ir_en,
    output logic             opnd_en,
    output logic             alu_en,
    output logic             rf_we,
    output logic             pc_en,
    output logic [1:0]       pc_sel,
    output logic [2:0]       state,
    output logic             busy,
    output logic             fault,
    output logic [CNT_W-1:0] instret
);

    localparam int TO_W = $clog2(MEM_TIMEOUT + 1);

    seq_state_e       state_r;
    seq_state_e       state_next_s;
    logic             commit_s;
    logic             taken_r;
    logic             taken_s;
    logic [CNT_W-1:0] instret_r;
    logic             req_wait_s;
    logic             to_clear_s;
    logic             expired_s;
    logic             live_s;

    assign req_wait_s = ((state_r == ST_FETCH) || (state_r == ST_MEM)) && !mem_ready;
    // Any state change restarts the guard, so it is zero on entry to FETCH or MEM.
    assign to_clear_s = (state_next_s != state_r);

    seq_timeout_counter #(
        .W (TO_W)
    ) u_timeout (
        .clk     (clk),
        .reset   (reset),
        .clear   (to_clear_s),
        .inc     (req_wait_s),
        .limit   (TO_W'(MEM_TIMEOUT)),
        .expired (expired_s)
    );

    // Next-state logic; commit_s marks the cycle an instruction retires.
    always_comb begin
        state_next_s = state_r;
        commit_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (run) begin
                    state_next_s = ST_FETCH;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_FETCH: begin
                if (mem_ready) begin
                    state_next_s = ST_DECODE;
                end else if (expired_s) begin
                    state_next_s = ST_FAULT;
                end else begin
                    state_next_s = ST_FETCH;
                end
            end
            ST_DECODE: begin
                if (!ctrl_valid) begin
                    state_next_s = ST_FAULT;
                end else begin
                    state_next_s = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (mem_read || mem_write) begin
                    state_next_s = ST_MEM;
                end else if (reg_write) begin
                    state_next_s = ST_WB;
                end else begin
                    commit_s = 1'b1;
                end
            end
            ST_MEM: begin
                if (mem_ready) begin
                    if (mem_read) begin
                        state_next_s = ST_WB;
                    end else begin
                        commit_s = 1'b1;
                    end
                end else if (expired_s) begin
                    state_next_s = ST_FAULT;
                end else begin
                    state_next_s = ST_MEM;
                end
            end
            ST_WB: begin
                commit_s = 1'b1;
            end
            ST_FAULT: begin
                state_next_s = ST_FAULT;
            end
            default: begin
                state_next_s = ST_FAULT;
            end
        endcase
        if (commit_s) begin
            state_next_s = run ? ST_FETCH : ST_IDLE;
        end else begin
            state_next_s = state_next_s;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Taken bit captured in EXEC so a later commit still sees it after the ALU moves on.
    always_ff @(posedge clk) begin
        if (reset) begin
            taken_r <= 1'b0;
        end else if (state_r == ST_EXEC) begin
            taken_r <= branch_taken;
        end else begin
            taken_r <= taken_r;
        end
    end

    // Retired-instruction counter, wraps naturally.
    always_ff @(posedge clk) begin
        if (reset) begin
            instret_r <= {CNT_W{1'b0}};
        end else if (commit_s) begin
            instret_r <= instret_r + CNT_W'(1);
        end else begin
            instret_r <= instret_r;
        end
    end

    // A branch commits inside EXEC, before taken_r has been written.
    assign taken_s = (state_r == ST_EXEC) ? branch_taken : taken_r;
    assign live_s  = !reset;

    // Datapath strobes decoded from the registered state; suppressed while reset is asserted.
    always_comb begin
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_addr_sel = 1'b0;
        ir_en        = 1'b0;
        opnd_en      = 1'b0;
        alu_en       = 1'b0;
        rf_we        = 1'b0;
        case (state_r)
            ST_FETCH: begin
                mem_req = live_s;
                ir_en   = live_s && mem_ready;
            end
            ST_DECODE: begin
                opnd_en = live_s;
            end
            ST_EXEC: begin
                alu_en = live_s;
            end
            ST_MEM: begin
                mem_req      = live_s;
                mem_addr_sel = 1'b1;
                mem_we       = live_s && mem_write;
            end
            ST_WB: begin
                rf_we = live_s;
            end
            default: begin
                mem_req = 1'b0;
            end
        endcase
        pc_en = live_s && commit_s;
        if (pc_en) begin
            pc_sel = pc_sel_f(jump, taken_s);
        end else begin
            pc_sel = PC_SEL_PLUS4;
        end
    end

    assign state   = state_r;
    assign fault   = (state_r == ST_FAULT);
    assign busy    = (state_r != ST_IDLE) && (state_r != ST_FAULT);
    assign instret = instret_r;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Directed self-checking bench for multicycle_sequencer (MEM_TIMEOUT = 4, 4-bit instret to reach wrap).
module tb_multicycle_sequencer;

    logic       clk;
    logic       reset;
    logic       run;
    logic       ctrl_valid;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       jump;
    logic       branch_taken;
    logic       mem_ready;
    logic       mem_req;
    logic       mem_we;
    logic       mem_addr_sel;
    logic       ir_en;
    logic       opnd_en;
    logic       alu_en;
    logic       rf_we;
    logic       pc_en;
    logic [1:0] pc_sel;
    logic [2:0] state;
    logic       busy;
    logic       fault;
    logic [3:0] instret;

    int total;
    int passed;

    multicycle_sequencer #(
        .CNT_W       (4),
        .MEM_TIMEOUT (4)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .run          (run),
        .ctrl_valid   (ctrl_valid),
        .reg_write    (reg_write),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .jump         (jump),
        .branch_taken (branch_taken),
        .mem_ready    (mem_ready),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_addr_sel (mem_addr_sel),
        .ir_en        (ir_en),
        .opnd_en      (opnd_en),
        .alu_en       (alu_en),
        .rf_we        (rf_we),
        .pc_en        (pc_en),
        .pc_sel       (pc_sel),
        .state        (state),
        .busy         (busy),
        .fault        (fault),
        .instret      (instret)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic set_flags(input logic cv, input logic rw, input logic mr, input logic mw, input logic j);
        ctrl_valid = cv;
        reg_write  = rw;
        mem_read   = mr;
        mem_write  = mw;
        jump       = j;
    endtask

    initial begin
        total = 0;
        passed = 0;
        reset = 1'b1;
        run = 1'b0;
        mem_ready = 1'b0;
        branch_taken = 1'b0;
        set_flags(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        nxt();
        nxt();
        chk("rst_state", state, 0);
        chk("rst_instret", instret, 0);
        chk("rst_fault", fault, 0);
        chk("rst_busy", busy, 0);
        chk("rst_mem_req", mem_req, 0);

        // ADD, zero-wait fetch
        reset = 1'b0;
        run = 1'b1;
        mem_ready = 1'b1;
        set_flags(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        nxt();
        chk("add_fetch_state", state, 1);
        chk("add_fetch_ir_en", ir_en, 1);
        chk("add_fetch_req", mem_req, 1);
        chk("add_fetch_sel", mem_addr_sel, 0);
        chk("add_busy", busy, 1);
        nxt();
        chk("add_decode_state", state, 2);
        chk("add_opnd_en", opnd_en, 1);
        nxt();
        chk("add_exec_state", state, 3);
        chk("add_alu_en", alu_en, 1);
        chk("add_exec_pc_en", pc_en, 0);
        nxt();
        chk("add_wb_state", state, 5);
        chk("add_wb_rf_we", rf_we, 1);
        chk("add_wb_pc_en", pc_en, 1);
        chk("add_wb_pc_sel", pc_sel, 0);
        chk("add_wb_instret", instret, 0);
        nxt();
        chk("add_next_fetch", state, 1);
        chk("add_instret", instret, 1);

        // LW with three data wait cycles
        set_flags(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        nxt();
        nxt();
        chk("lw_exec_state", state, 3);
        mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            nxt();
            chk("lw_wait_state", state, 4);
            chk("lw_wait_req", mem_req, 1);
            chk("lw_wait_sel", mem_addr_sel, 1);
            chk("lw_wait_we", mem_we, 0);
            chk("lw_wait_ir_en", ir_en, 0);
        end
        nxt();
        mem_ready = 1'b1;
        #1;
        chk("lw_ready_state", state, 4);
        chk("lw_ready_req", mem_req, 1);
        chk("lw_ready_pc_en", pc_en, 0);
        nxt();
        chk("lw_wb_state", state, 5);
        chk("lw_wb_rf_we", rf_we, 1);
        chk("lw_wb_pc_en", pc_en, 1);
        nxt();
        chk("lw_instret", instret, 2);

        // Taken BEQ commits from EXEC
        set_flags(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        branch_taken = 1'b1;
        nxt();
        nxt();
        chk("beq_exec_state", state, 3);
        chk("beq_pc_en", pc_en, 1);
        chk("beq_pc_sel", pc_sel, 1);
        chk("beq_rf_we", rf_we, 0);
        nxt();
        chk("beq_next_fetch", state, 1);
        chk("beq_instret", instret, 3);

        // JAL via WB
        set_flags(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        branch_taken = 1'b0;
        nxt();
        nxt();
        chk("jal_exec_pc_en", pc_en, 0);
        nxt();
        chk("jal_wb_state", state, 5);
        chk("jal_pc_en", pc_en, 1);
        chk("jal_pc_sel", pc_sel, 2);
        chk("jal_rf_we", rf_we, 1);
        nxt();
        chk("jal_instret", instret, 4);

        // Unsupported opcode
        set_flags(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        nxt();
        chk("bad_decode_state", state, 2);
        nxt();
        chk("bad_fault_state", state, 7);
        chk("bad_fault", fault, 1);
        chk("bad_busy", busy, 0);
        for (int i = 0; i < 3; i++) begin
            nxt();
            chk("fault_sticky", fault, 1);
            chk("fault_no_req", mem_req, 0);
        end
        reset = 1'b1;
        nxt();
        chk("fault_rst_state", state, 0);
        chk("fault_rst_fault", fault, 0);
        chk("fault_rst_instret", instret, 0);

        // Fetch never ready: four request cycles then FAULT
        reset = 1'b0;
        mem_ready = 1'b0;
        set_flags(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            nxt();
            chk("to_fetch_state", state, 1);
            chk("to_fetch_req", mem_req, 1);
        end
        nxt();
        chk("to_fault_state", state, 7);
        chk("to_fault_req", mem_req, 0);
        chk("to_fault_flag", fault, 1);
        reset = 1'b1;
        nxt();

        // SW with run dropped during MEM
        reset = 1'b0;
        mem_ready = 1'b1;
        set_flags(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        nxt();
        nxt();
        nxt();
        nxt();
        chk("sw_mem_state", state, 4);
        chk("sw_mem_we", mem_we, 1);
        chk("sw_mem_sel", mem_addr_sel, 1);
        chk("sw_mem_rf_we", rf_we, 0);
        run = 1'b0;
        #1;
        chk("sw_pc_en", pc_en, 1);
        chk("sw_pc_sel", pc_sel, 0);
        nxt();
        chk("sw_idle_state", state, 0);
        chk("sw_instret", instret, 1);
        chk("sw_idle_busy", busy, 0);
        nxt();
        chk("sw_stay_idle", state, 0);

        // Reset in EXEC of a committing branch
        run = 1'b1;
        set_flags(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        branch_taken = 1'b1;
        nxt();
        nxt();
        nxt();
        chk("rexec_state", state, 3);
        reset = 1'b1;
        #1;
        chk("rexec_pc_en", pc_en, 0);
        chk("rexec_rf_we", rf_we, 0);
        nxt();
        chk("rexec_state_idle", state, 0);
        chk("rexec_instret", instret, 0);

        // Sixteen not-taken branches wrap the 4-bit counter
        reset = 1'b0;
        branch_taken = 1'b0;
        for (int i = 0; i < 16; i++) begin
            nxt();
            chk("wrap_instret", instret, i);
            nxt();
            nxt();
            chk("wrap_pc_en", pc_en, 1);
            chk("wrap_pc_sel", pc_sel, 0);
        end
        nxt();
        chk("wrap_state", state, 1);
        chk("wrap_instret_zero", instret, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
